br_pred_gshare: RTL and testbench
=================================

Name: br_pred_gshare

Overview:
- Parametrised successor to the 4-entry per-PC branch predictor.
- Holds a table of 2^INDEX_W two-bit hysteresis counters. Indexing is selectable: bimodal (PC only) or gshare (PC XOR global history).
- Predicts beq/bne in IF, takes resolution results from the ID comparator, and repairs a speculative global history register (GHR) on mispredict.
- Includes saturating branch and mispredict counters for performance measurement.

Parameters:
- INDEX_W, 4, table index width; table depth is 2^INDEX_W.
- GHR_W, 4, global history length; legal range 1..INDEX_W.
- MODE, 1, 0 = bimodal (index = PC bits), 1 = gshare (index = PC bits XOR zero-extended GHR).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes all state
- if_pc_idx  in  INDEX_W  PC[INDEX_W+1:2] of the instruction in IF
- if_opcode  in  6  opcode in IF; a branch is 6'h4 (beq) or 6'h5 (bne)
- pred_taken  out  1  prediction for the IF instruction
- pred_idx  out  INDEX_W  table index used; carried down the pipe to ID
- pred_ghr  out  GHR_W  GHR snapshot used for the lookup; carried to ID
- upd_idx  in  INDEX_W  pred_idx of the branch now in ID
- upd_ghr  in  GHR_W  pred_ghr of the branch now in ID
- upd_result  in  2  comparator result: 00 correct, 01 predicted taken but not taken, 10 no branch, 11 predicted not taken but taken
- branch_cnt  out  CNT_W  resolved branches (upd_result != 10)
- mispred_cnt  out  CNT_W  mispredicts (upd_result 01 or 11)

Behaviour:
- Counter states: NT1=00, NT2=01, T1=10, T2=11. Predict taken iff state[1]=1.
- Counter transitions, wrong = upd_result 01 or 11, right = 00:
  - NT1: wrong -> NT2; otherwise stay.
  - NT2: wrong -> T1; right -> NT1.
  - T1: wrong -> NT2; right -> T2.
  - T2: wrong -> T1; otherwise stay.
  - upd_result 10 leaves the entry unchanged.
- Lookup is combinational, zero latency.
  - idx = if_pc_idx (MODE 0) or if_pc_idx ^ {0, ghr} (MODE 1).
  - pred_taken = is_branch & table[idx][1]; pred_idx = idx; pred_ghr = ghr.
- Same-cycle bypass: if an update targets idx in the same cycle, the lookup uses the entry's next state (the forwarded value).
- Table write at posedge when !rst & !stall & upd_result != 10: table[upd_idx] <= next state.
- GHR at posedge when !rst & !stall, first match wins:
  1. upd_result 01 -> ghr <= {upd_ghr[GHR_W-2:0], 0}.
  2. upd_result 11 -> ghr <= {upd_ghr[GHR_W-2:0], 1}.
  3. Else, if the IF instruction is a branch -> ghr <= {ghr[GHR_W-2:0], pred_taken}.
  4. Else hold.
  - Repair beats the speculative shift because the IF instruction is flushed on mispredict.
  - For GHR_W=1 the shifted-in bit is the whole register.
- Statistics, same enable as the table write:
  - branch_cnt +1 on upd_result != 10.
  - mispred_cnt +1 on upd_result 01 or 11.
  - Both saturate at all-ones; no wrap.
- stall=1: table, GHR and counters all hold. This prevents a branch held in ID from being counted twice. Combinational outputs stay live.
- Reset:
  - All entries become NT1; ghr=0; branch_cnt=0; mispred_cnt=0.
  - pred_taken therefore reads 0 and pred_ghr reads 0 in the first cycle after reset.
  - Reset mid-operation discards any in-flight update and overrides stall.
- Out-of-range GHR_W (above INDEX_W) is a compile-time error via a generate check.

Decomposition:
- Package br_pred_pkg:
  - counter state localparams NT1/NT2/T1/T2;
  - upd_result codes RES_OK=00, RES_WRONG_T=01, RES_NOBR=10, RES_WRONG_NT=11;
  - opcodes OP_BEQ=6'h4, OP_BNE=6'h5.
- Sub-module br_pred_ctr_next: combinational next-state for one counter from (state, upd_result). It is used for both the table write and the bypass path.

Test Plan:
- Reset, then if_opcode=4, if_pc_idx=3 -> pred_taken=0, pred_ghr=0, both stats counters 0.
- MODE=0: upd_idx=5 with upd_result=11 for two cycles (NT1->NT2->T1), then lookup idx 5 with beq -> pred_taken=1; with if_opcode=0 -> pred_taken=0.
- MODE=1, ghr=4'b0000:
  - three beq lookups predicted not taken -> ghr stays 0000.
  - then upd_result=11 with upd_ghr=4'b0101 in the same cycle as a beq lookup -> ghr=4'b1011 (repair wins).
- Same-cycle bypass: table[2]=T1; upd_idx=2, upd_result=01 while looking up idx 2 -> pred_taken=0 (forwarded NT2).
- stall=1 held 3 cycles with upd_result=11 -> table, ghr, branch_cnt, mispred_cnt unchanged; deassert -> single increment of each counter.
- CNT_W=4: apply 20 upd_result=01 events -> branch_cnt=mispred_cnt=15 (saturated); then assert rst mid-stream -> both 0, all entries NT1.

Source files
------------

// File: rtl/br_pred_gshare_pkg.sv
// Shared encodings for the gshare/bimodal branch predictor: counter states,
// resolution codes and branch opcodes.
`default_nettype none

package br_pred_pkg;

  localparam logic [1:0] NT1 = 2'b00;
  localparam logic [1:0] NT2 = 2'b01;
  localparam logic [1:0] T1  = 2'b10;
  localparam logic [1:0] T2  = 2'b11;

  localparam logic [1:0] RES_OK       = 2'b00;
  localparam logic [1:0] RES_WRONG_T  = 2'b01;
  localparam logic [1:0] RES_NOBR     = 2'b10;
  localparam logic [1:0] RES_WRONG_NT = 2'b11;

  localparam logic [5:0] OP_BEQ = 6'h4;
  localparam logic [5:0] OP_BNE = 6'h5;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_pred_ctr_next.sv
// Next state of one two-bit hysteresis counter given a resolution result.
`default_nettype none

module br_pred_ctr_next
  import br_pred_pkg::*;
(
  input  logic [1:0] state,
  input  logic [1:0] result,
  output logic [1:0] next_state
);

  logic wrong;
  logic right;

  always_comb begin
    wrong      = (result == RES_WRONG_T) || (result == RES_WRONG_NT);
    right      = (result == RES_OK);
    next_state = state;
    case (state)
      NT1: if (wrong) next_state = NT2;
      NT2: begin
        if (wrong)      next_state = T1;
        else if (right) next_state = NT1;
      end
      T1: begin
        if (wrong)      next_state = NT2;
        else if (right) next_state = T2;
      end
      default: if (wrong) next_state = T1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/br_pred_gshare.sv
// Two-bit counter branch predictor with bimodal or gshare indexing, a
// speculative global history register with mispredict repair, and statistics.
`default_nettype none

module br_pred_gshare
  import br_pred_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int GHR_W   = 4,
  parameter int MODE    = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [INDEX_W-1:0] if_pc_idx,
  input  logic [5:0]         if_opcode,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_idx,
  output logic [GHR_W-1:0]   pred_ghr,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic [GHR_W-1:0]   upd_ghr,
  input  logic [1:0]         upd_result,
  output logic [CNT_W-1:0]   branch_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  generate
    if (GHR_W < 1 || GHR_W > INDEX_W) begin : g_ghr_w_check
      $error("br_pred_gshare: GHR_W must lie in 1..INDEX_W");
    end
  endgenerate

  logic [1:0]         ctr_table [2**INDEX_W];
  logic [GHR_W-1:0]   ghr;
  logic [INDEX_W-1:0] ghr_ext;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         upd_next;
  logic [1:0]         lookup_state;
  logic               is_branch;
  logic               upd_valid;
  logic               upd_wrong;

  // Shift one outcome into a history; with GHR_W=1 the new bit is the whole register.
  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] hist,
                                                 input logic bit_in);
    logic [GHR_W-1:0] res;
    res    = hist << 1;
    res[0] = bit_in;
    return res;
  endfunction

  br_pred_ctr_next u_upd_next (
    .state      (ctr_table[upd_idx]),
    .result     (upd_result),
    .next_state (upd_next)
  );

  always_comb begin
    ghr_ext              = '0;
    ghr_ext[GHR_W-1:0]   = ghr;
    idx                  = (MODE == 0) ? if_pc_idx : (if_pc_idx ^ ghr_ext);
    is_branch            = is_branch_op(if_opcode);
    upd_valid            = (upd_result != RES_NOBR);
    upd_wrong            = (upd_result == RES_WRONG_T) || (upd_result == RES_WRONG_NT);
    // Forward the in-flight update so a lookup never sees a stale entry.
    lookup_state         = (upd_valid && (upd_idx == idx)) ? upd_next : ctr_table[idx];
    pred_taken           = is_branch & lookup_state[1];
    pred_idx             = idx;
    pred_ghr             = ghr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_table   <= '{default: NT1};
      ghr         <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (!stall) begin
      if (upd_valid) begin
        ctr_table[upd_idx] <= upd_next;
        if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (upd_wrong && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);

      // Repair outranks the speculative shift: the IF instruction gets flushed.
      if (upd_result == RES_WRONG_T)       ghr <= shift_in(upd_ghr, 1'b0);
      else if (upd_result == RES_WRONG_NT) ghr <= shift_in(upd_ghr, 1'b1);
      else if (is_branch)                  ghr <= shift_in(ghr, pred_taken);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_br_pred_gshare.sv
// Randomised plus directed bench for br_pred_gshare: a bimodal 16-bit-stat
// instance and a gshare 4-bit-stat instance share stimulus, each with a model.
`default_nettype none

module tb_br_pred_gshare;

  logic       clk = 1'b0;
  logic       rst, stall;
  logic [3:0] pc, uidx, ughr;
  logic [5:0] op;
  logic [1:0] res;

  logic        bi_pred, gs_pred;
  logic [3:0]  bi_pidx, gs_pidx, bi_pghr, gs_pghr;
  logic [15:0] bi_bcnt, bi_mcnt;
  logic [3:0]  gs_bcnt, gs_mcnt;

  always #5 clk = ~clk;

  br_pred_gshare #(.INDEX_W(4), .GHR_W(4), .MODE(0), .CNT_W(16)) d_bi (
    .clk(clk), .rst(rst), .stall(stall), .if_pc_idx(pc), .if_opcode(op),
    .pred_taken(bi_pred), .pred_idx(bi_pidx), .pred_ghr(bi_pghr),
    .upd_idx(uidx), .upd_ghr(ughr), .upd_result(res),
    .branch_cnt(bi_bcnt), .mispred_cnt(bi_mcnt));

  br_pred_gshare #(.INDEX_W(4), .GHR_W(4), .MODE(1), .CNT_W(4)) d_gs (
    .clk(clk), .rst(rst), .stall(stall), .if_pc_idx(pc), .if_opcode(op),
    .pred_taken(gs_pred), .pred_idx(gs_pidx), .pred_ghr(gs_pghr),
    .upd_idx(uidx), .upd_ghr(ughr), .upd_result(res),
    .branch_cnt(gs_bcnt), .mispred_cnt(gs_mcnt));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: index 0 = bimodal instance, 1 = gshare instance.
  int tbl [2][16];
  int ghr_m [2];
  int bc [2];
  int mc [2];
  int cap [2] = '{65535, 15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int s, input int r);
    if (r == 2) return s;
    if (r == 1 || r == 3) return (s < 2) ? s + 1 : s - 1;
    if (s < 2) return (s > 0) ? s - 1 : 0;
    return (s < 3) ? s + 1 : 3;
  endfunction

  function automatic int m_idx(input int m);
    return (m == 1) ? (int'(pc) ^ ghr_m[m]) : int'(pc);
  endfunction

  function automatic int m_pred(input int m);
    int i, s;
    i = m_idx(m);
    s = (res != 2'd2 && int'(uidx) == i) ? nxt(tbl[m][uidx], res) : tbl[m][i];
    return ((op == 6'd4 || op == 6'd5) && s >= 2) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int k = 0; k < 16; k++) tbl[m][k] = 0;
        ghr_m[m] = 0; bc[m] = 0; mc[m] = 0;
      end else if (!stall) begin
        int p;
        p = m_pred(m);
        if (res != 2'd2) begin
          tbl[m][uidx] = nxt(tbl[m][uidx], res);
          if (bc[m] < cap[m]) bc[m]++;
          if (res[0] && mc[m] < cap[m]) mc[m]++;
        end
        if (res == 2'd1)                   ghr_m[m] = (int'(ughr) << 1) & 15;
        else if (res == 2'd3)              ghr_m[m] = ((int'(ughr) << 1) | 1) & 15;
        else if (op == 6'd4 || op == 6'd5) ghr_m[m] = ((ghr_m[m] << 1) | p) & 15;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bi_pred",  32'(bi_pred), 32'(m_pred(0)));
      check("bi_pidx",  32'(bi_pidx), 32'(m_idx(0)));
      check("bi_pghr",  32'(bi_pghr), 32'(ghr_m[0]));
      check("bi_bcnt",  32'(bi_bcnt), 32'(bc[0]));
      check("bi_mcnt",  32'(bi_mcnt), 32'(mc[0]));
      check("gs_pred",  32'(gs_pred), 32'(m_pred(1)));
      check("gs_pidx",  32'(gs_pidx), 32'(m_idx(1)));
      check("gs_pghr",  32'(gs_pghr), 32'(ghr_m[1]));
      check("gs_bcnt",  32'(gs_bcnt), 32'(bc[1]));
      check("gs_mcnt",  32'(gs_mcnt), 32'(mc[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc = '0; op = '0; uidx = '0; ughr = '0; res = 2'd2;
    cyc(); cyc();
    rst = 1'b0; chk_en = 1'b1;

    // Reset state
    op = 6'd4; pc = 4'd3;
    @(negedge clk);
    check("rst_bi_pred", 32'(bi_pred), 0);
    check("rst_gs_pred", 32'(gs_pred), 0);
    check("rst_gs_pghr", 32'(gs_pghr), 0);
    check("rst_bi_bcnt", 32'(bi_bcnt), 0);
    check("rst_gs_mcnt", 32'(gs_mcnt), 0);
    cyc();

    // Bimodal: train idx 5 NT1 -> NT2 -> T1
    op = 6'd0; uidx = 4'd5; res = 2'd3; ughr = 4'd0;
    cyc(); cyc();
    res = 2'd2; op = 6'd4; pc = 4'd5;
    @(negedge clk);
    check("bi_trained_beq", 32'(bi_pred), 1);
    check("bi_bcnt_2", 32'(bi_bcnt), 2);
    cyc();
    op = 6'd0;
    @(negedge clk);
    check("bi_trained_nobr", 32'(bi_pred), 0);

    // Gshare: untaken lookups keep GHR at 0, then repair wins over shift
    rst = 1'b1; cyc(); rst = 1'b0;
    op = 6'd4; res = 2'd2;
    for (int i = 0; i < 3; i++) begin
      pc = 4'($urandom);
      cyc();
    end
    @(negedge clk);
    check("gs_ghr_zero", 32'(gs_pghr), 0);
    op = 6'd4; pc = 4'd9; res = 2'd3; uidx = 4'd7; ughr = 4'b0101;
    cyc();
    res = 2'd2; op = 6'd0;
    @(negedge clk);
    check("gs_ghr_repair", 32'(gs_pghr), 32'hB);

    // Same-cycle bypass on idx 2 (bimodal)
    rst = 1'b1; cyc(); rst = 1'b0;
    uidx = 4'd2; res = 2'd3; ughr = 4'd0; op = 6'd0;
    cyc(); cyc();
    res = 2'd2; op = 6'd4; pc = 4'd2;
    @(negedge clk);
    check("bi_t1_pred", 32'(bi_pred), 1);
    res = 2'd1;
    #1;
    check("bi_bypass_pred", 32'(bi_pred), 0);
    cyc();

    // Stall holds everything, including stats
    res = 2'd3; op = 6'd0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check("stall_bcnt", 32'(bi_bcnt), 3);
      check("stall_mcnt", 32'(bi_mcnt), 3);
    end
    stall = 1'b0;
    cyc();
    res = 2'd2;
    @(negedge clk);
    check("unstall_bcnt", 32'(bi_bcnt), 4);
    check("unstall_mcnt", 32'(bi_mcnt), 4);

    // Saturation on 4-bit stats, then reset mid-stream overriding stall
    res = 2'd1;
    repeat (20) cyc();
    @(negedge clk);
    check("gs_bcnt_sat", 32'(gs_bcnt), 15);
    check("gs_mcnt_sat", 32'(gs_mcnt), 15);
    check("bi_bcnt_24",  32'(bi_bcnt), 24);
    rst = 1'b1; stall = 1'b1;
    cyc();
    rst = 1'b0; stall = 1'b0; res = 2'd2; op = 6'd4;
    @(negedge clk);
    check("rst_gs_bcnt", 32'(gs_bcnt), 0);
    check("rst_gs_mcnt2", 32'(gs_mcnt), 0);
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      check("rst_entry_bi", 32'(bi_pred), 0);
      check("rst_entry_gs", 32'(gs_pred), 0);
      cyc();
    end

    // Randomised traffic
    repeat (600) begin
      rst   = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      pc    = 4'($urandom);
      uidx  = 4'($urandom);
      ughr  = 4'($urandom);
      op    = ($urandom_range(0, 3) != 0) ? 6'(4 + $urandom_range(0, 1)) : 6'($urandom);
      res   = 2'($urandom);
      cyc();
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
